fb_scanout: RTL and testbench

- Read-side counterpart of the photo-album framebuffer writer.
- On `start`, fetches the framebuffer base pointer from image memory (IM), then reads one full H_RES x V_RES frame of 24-bit RGB words, and streams the pixels out on a valid/ready pixel interface to the display/checker.
- Absorbs IM read latency and downstream backpressure with a small FIFO.
- Shares the IM port with the writer; the arbiter is outside this block.

---
 rtl/dpa_pkg.sv | 37 +++
 rtl/px_fifo.sv | 70 +++++++
 rtl/fb_scanout.sv | 168 ++++++++++++++++
 tb/tb_fb_scanout.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpa_pkg.sv
// -----------------------------------------------------------------------------
// dpa_pkg -- definitions shared by the photo-album framebuffer writer and
// the framebuffer scan-out reader.
//
// Contents:
//   ADDR_W, PIX_W  image-memory word address width and RGB pixel width
//   TAG_W          pixel plus {sof, eol} tags, as stored in the scan-out FIFO
//   FB_PTR_ADDR    IM word holding the framebuffer base pointer
//   scan_state_e   scan-out FSM encoding
//   rgb_to_gray()  luma approximation used when GRAY_OUT_EN is defined
// -----------------------------------------------------------------------------
package dpa_pkg;

  localparam int ADDR_W = 20;
  localparam int PIX_W  = 24;
  localparam int TAG_W  = PIX_W + 2;

  localparam logic [ADDR_W-1:0] FB_PTR_ADDR = 20'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PTR_REQ,
    ST_PTR_WAIT,
    ST_SCAN,
    ST_DRAIN
  } scan_state_e;

  // Y = (R + 2G + B) / 4. The 10-bit sum cannot overflow (max 1020).
  function automatic logic [PIX_W-1:0] rgb_to_gray(input logic [PIX_W-1:0] rgb);
    logic [9:0] sum;
    logic [7:0] y;
    sum = {2'b00, rgb[23:16]} + {1'b0, rgb[15:8], 1'b0} + {2'b00, rgb[7:0]};
    y   = 8'(sum >> 2);
    return {y, y, y};
  endfunction

endpackage

// File: rtl/px_fifo.sv
// -----------------------------------------------------------------------------
// px_fifo -- synchronous FIFO buffering tagged pixels between the image
// memory read pipeline and the pixel output interface.
//
// Parameters: WIDTH entry width, DEPTH entries (power of two, >= 2).
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   push_i, data_i  write request and data
//   pop_i           read request; data_o is the head entry (show-ahead)
//   full_o, empty_o occupancy flags
//   count_o         number of stored entries (0..DEPTH)
// A push and a pop in the same cycle on a full FIFO are both honoured.
// -----------------------------------------------------------------------------
module px_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // NOTE: storage has no reset; the empty flag guards every read, and
  // leaving it out keeps the array as plain flops or a register file.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fb_scanout.sv
// -----------------------------------------------------------------------------
// fb_scanout -- reads one H_RES x V_RES frame of 24-bit RGB words from image
// memory and streams it on a valid/ready pixel interface.
//
// On start: fetch the base pointer from IM[FB_PTR_ADDR], then issue one read
// per cycle at base+index while the FIFO has room for the result, tag each
// pixel with sof/eol, and finish once the last pixel has been accepted.
//
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   start          one-cycle pulse, honoured only when idle
//   IM_A, IM_Q     image memory address / read data (1-cycle read latency)
//   IM_WEN         image memory write enable, held at 1 (read)
//   px_data        pixel at the FIFO head, 0 when nothing is valid
//   px_valid, px_ready  pixel handshake
//   px_sof, px_eol first pixel of frame / last pixel of line
//   busy           from accepted start until the last pixel is accepted
//   frame_done     one-cycle pulse after the last pixel handshake
//
// Build option: define GRAY_OUT_EN to output {Y,Y,Y} with Y=(R+2G+B)>>2.
// -----------------------------------------------------------------------------
module fb_scanout
  import dpa_pkg::*;
#(
  parameter int                H_RES       = 256,
  parameter int                V_RES       = 256,
  parameter logic [ADDR_W-1:0] FB_PTR_ADDR = dpa_pkg::FB_PTR_ADDR,
  parameter int                FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] IM_A,
  input  logic [PIX_W-1:0]  IM_Q,
  output logic              IM_WEN,
  output logic [PIX_W-1:0]  px_data,
  output logic              px_valid,
  input  logic              px_ready,
  output logic              px_sof,
  output logic              px_eol,
  output logic              busy,
  output logic              frame_done
);

  localparam int                CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(H_RES * V_RES - 1);
  localparam logic [ADDR_W-1:0] H_MASK   = ADDR_W'(H_RES - 1);

  scan_state_e       state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
  logic              inflight_q, inflight_d;
  logic              tag_sof_q, tag_sof_d;
  logic              tag_eol_q, tag_eol_d;

  logic              issue;
  logic              done_c;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  occupancy;
  logic              fifo_full;
  logic              fifo_empty;
  logic [TAG_W-1:0]  fifo_head;
  logic [PIX_W-1:0]  head_px;
  logic [PIX_W-1:0]  out_px;

  // Entries already stored plus the one read still on its way back; issuing
  // only below FIFO_DEPTH guarantees every returning word has a slot.
  assign occupancy = fifo_count + CNT_W'(inflight_q);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case statement can infer a latch.
    state_d   = state_q;
    base_d    = base_q;
    pix_cnt_d = pix_cnt_q;
    IM_A      = '0;
    issue     = 1'b0;
    done_c    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_PTR_REQ;
      end
      ST_PTR_REQ: begin
        IM_A    = FB_PTR_ADDR;
        state_d = ST_PTR_WAIT;
      end
      ST_PTR_WAIT: begin
        base_d    = IM_Q[ADDR_W-1:0];
        pix_cnt_d = '0;
        state_d   = ST_SCAN;
      end
      ST_SCAN: begin
        // Address wraps modulo 2^20 by construction of the adder width.
        IM_A = base_q + pix_cnt_q;
        if (!fifo_full && (occupancy < CNT_W'(FIFO_DEPTH))) begin
          issue = 1'b1;
          if (pix_cnt_q == LAST_IDX) state_d   = ST_DRAIN;
          else                       pix_cnt_d = pix_cnt_q + ADDR_W'(1);
        end
      end
      ST_DRAIN: begin
        if (fifo_empty && !inflight_q) begin
          done_c  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Tags travel alongside the outstanding read and join the data on capture.
  assign inflight_d = issue;
  assign tag_sof_d  = issue && (pix_cnt_q == '0);
  assign tag_eol_d  = issue && ((pix_cnt_q & H_MASK) == H_MASK);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      pix_cnt_q  <= '0;
      inflight_q <= 1'b0;
      tag_sof_q  <= 1'b0;
      tag_eol_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      pix_cnt_q  <= pix_cnt_d;
      inflight_q <= inflight_d;
      tag_sof_q  <= tag_sof_d;
      tag_eol_q  <= tag_eol_d;
    end
  end

  px_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (FIFO_DEPTH)
  ) u_px_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (inflight_q),
    .data_i  ({IM_Q, tag_sof_q, tag_eol_q}),
    .pop_i   (px_ready),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign head_px = fifo_head[TAG_W-1:2];

`ifdef GRAY_OUT_EN
  assign out_px = rgb_to_gray(head_px);
`else
  assign out_px = head_px;
`endif

  // Outputs are forced to 0 while empty so reset clears them even though
  // the FIFO storage itself is not reset.
  assign px_valid   = !fifo_empty;
  assign px_data    = px_valid ? out_px : '0;
  assign px_sof     = px_valid && fifo_head[1];
  assign px_eol     = px_valid && fifo_head[0];
  assign IM_WEN     = 1'b1;
  assign frame_done = done_c;
  assign busy       = (state_q != ST_IDLE) && !done_c;

endmodule

// File: tb/tb_fb_scanout.sv
module tb_fb_scanout;

  localparam int H     = 4;
  localparam int V     = 4;
  localparam int N     = H * V;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [19:0] IM_A;
  logic [23:0] IM_Q;
  logic        IM_WEN;
  logic [23:0] px_data;
  logic        px_valid;
  logic        px_ready;
  logic        px_sof;
  logic        px_eol;
  logic        busy;
  logic        frame_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fb_scanout #(
    .H_RES      (H),
    .V_RES      (V),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .IM_A       (IM_A),
    .IM_Q       (IM_Q),
    .IM_WEN     (IM_WEN),
    .px_data    (px_data),
    .px_valid   (px_valid),
    .px_ready   (px_ready),
    .px_sof     (px_sof),
    .px_eol     (px_eol),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // Image memory model: synchronous read, data one cycle after address.
  logic [23:0] im_mem [logic [19:0]];
  always @(posedge clk) IM_Q <= im_mem.exists(IM_A) ? im_mem[IM_A] : 24'h0;

  logic [23:0] img [N];
  logic [19:0] frame_base;

  function automatic logic [23:0] exp_px(input logic [23:0] raw);
`ifdef GRAY_OUT_EN
    int y;
    y = (int'(raw[23:16]) + 2 * int'(raw[15:8]) + int'(raw[7:0])) / 4;
    return {y[7:0], y[7:0], y[7:0]};
`else
    return raw;
`endif
  endfunction

  // Observations from the last run_frame call.
  logic [23:0] rx_data [$];
  logic        rx_sof  [$];
  logic        rx_eol  [$];
  int          first_valid, first_hs, last_hs, done_cyc, max_lead;
  logic        start_busy, done_busy, post_fd, post_busy, hold_ok, wen_ok, timed_out;

  task automatic load_linear();
    im_mem.delete();
    im_mem[20'd1] = 24'h000100;
    for (int i = 0; i < N; i++) begin
      im_mem[20'h00100 + 20'(i)] = 24'(i);
      img[i] = 24'(i);
    end
    frame_base = 20'h00100;
  endtask

  // Pulses start, then watches the interface until frame_done (bounded).
  task automatic run_frame(input int ready_pct, input int restart_cyc);
    int          cyc;
    int          lead;
    logic [19:0] off;
    logic        prev_stall;
    logic [23:0] prev_data;
    logic        prev_sof, prev_eol;
    rx_data.delete(); rx_sof.delete(); rx_eol.delete();
    first_valid = -1; first_hs = -1; last_hs = -1; done_cyc = -1; max_lead = 0;
    done_busy = 1'b1; hold_ok = 1'b1; wen_ok = 1'b1; prev_stall = 1'b0;
    prev_data = '0; prev_sof = 1'b0; prev_eol = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    start_busy = busy;
    while (done_cyc < 0 && cyc < 500) begin
      start    = (cyc == restart_cyc);
      px_ready = ($urandom_range(99) < ready_pct);
      if (IM_WEN !== 1'b1) wen_ok = 1'b0;
      if (px_valid && first_valid < 0) first_valid = cyc;
      if (prev_stall && (!px_valid || px_data !== prev_data ||
                         px_sof !== prev_sof || px_eol !== prev_eol)) hold_ok = 1'b0;
      off = IM_A - frame_base;
      if (busy && off < 20'(N)) begin
        lead = int'(off) - rx_data.size();
        if (lead > max_lead) max_lead = lead;
      end
      if (frame_done) begin
        done_cyc  = cyc;
        done_busy = busy;
      end else if (px_valid && px_ready) begin
        rx_data.push_back(px_data);
        rx_sof.push_back(px_sof);
        rx_eol.push_back(px_eol);
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
      end
      prev_stall = px_valid && !px_ready;
      prev_data  = px_data;
      prev_sof   = px_sof;
      prev_eol   = px_eol;
      @(posedge clk); #1;
      cyc++;
    end
    start     = 1'b0;
    px_ready  = 1'b0;
    timed_out = (done_cyc < 0);
    post_fd   = frame_done;
    post_busy = busy;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({IM_A, IM_WEN, px_valid, px_data, px_sof, px_eol, busy, frame_done} !==
        {20'h0, 1'b1, 1'b0, 24'h0, 4'h0}) begin
      bad++;
      $display("FAIL reset_outputs: got IM_A=%h WEN=%b v=%b d=%h sof=%b eol=%b busy=%b fd=%b, want IM_A=0 WEN=1 rest 0",
               IM_A, IM_WEN, px_valid, px_data, px_sof, px_eol, busy, frame_done);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy, px_valid, IM_A} !== {1'b0, 1'b0, 20'h0}) begin
      bad++;
      $display("FAIL idle_no_start: got busy=%b valid=%b IM_A=%h want 0 0 0", busy, px_valid, IM_A);
    end
  endtask

  task automatic test_full_rate();
    load_linear();
    run_frame(100, -1);
    total++;
    if (timed_out) begin bad++; $display("FAIL full_rate_timeout: frame_done missing, got none want pulse"); end
    total++;
    if (start_busy !== 1'b1) begin bad++; $display("FAIL busy_rise: got %b want 1", start_busy); end
    // start sampled at edge 1; PTR_REQ, PTR_WAIT, issue, capture -> valid after edge 5.
    total++;
    if (first_valid != 5) begin bad++; $display("FAIL first_valid_latency: got %0d want 5", first_valid); end
    total++;
    if (rx_data.size() != N) begin bad++; $display("FAIL full_rate_count: got %0d want %0d", rx_data.size(), N); end
    for (int i = 0; i < N && i < rx_data.size(); i++) begin
      total++;
      if ({rx_data[i], rx_sof[i], rx_eol[i]} !== {exp_px(img[i]), i == 0, (i % H) == H - 1}) begin
        bad++;
        $display("FAIL full_rate_px%0d: got %h/%b/%b want %h/%b/%b", i, rx_data[i], rx_sof[i], rx_eol[i],
                 exp_px(img[i]), i == 0, (i % H) == H - 1);
      end
    end
    total++;
    if (last_hs - first_hs != N - 1) begin bad++; $display("FAIL full_rate_gaps: got span %0d want %0d", last_hs - first_hs, N - 1); end
    total++;
    if (done_cyc != last_hs + 1) begin bad++; $display("FAIL done_timing: got cycle %0d want %0d", done_cyc, last_hs + 1); end
    total++;
    if (done_busy !== 1'b0) begin bad++; $display("FAIL busy_fall: got %b want 0 with frame_done", done_busy); end
    total++;
    if ({post_fd, post_busy} !== 2'b00) begin bad++; $display("FAIL done_pulse_width: got fd=%b busy=%b want 0 0", post_fd, post_busy); end
    total++;
    if (!wen_ok) begin bad++; $display("FAIL im_wen: got 0 during frame want 1"); end
  endtask

  task automatic test_backpressure();
    load_linear();
    run_frame(30, -1);
    total++;
    if (timed_out) begin bad++; $display("FAIL bp_timeout: frame_done missing, got none want pulse"); end
    total++;
    if (rx_data.size() != N) begin bad++; $display("FAIL bp_count: got %0d want %0d", rx_data.size(), N); end
    for (int i = 0; i < N && i < rx_data.size(); i++) begin
      total++;
      if ({rx_data[i], rx_sof[i], rx_eol[i]} !== {exp_px(img[i]), i == 0, (i % H) == H - 1}) begin
        bad++;
        $display("FAIL bp_px%0d: got %h/%b/%b want %h/%b/%b", i, rx_data[i], rx_sof[i], rx_eol[i],
                 exp_px(img[i]), i == 0, (i % H) == H - 1);
      end
    end
    total++;
    if (!hold_ok) begin bad++; $display("FAIL bp_hold: got output change under stall want stable"); end
    total++;
    if (max_lead > DEPTH) begin bad++; $display("FAIL bp_lead: got %0d want <= %0d", max_lead, DEPTH); end
    total++;
    if (done_cyc != last_hs + 1) begin bad++; $display("FAIL bp_done_timing: got %0d want %0d", done_cyc, last_hs + 1); end
  endtask

  task automatic test_addr_wrap();
    im_mem.delete();
    im_mem[20'd1] = 24'hAFFFFE;      // upper nibble must be ignored
    for (int i = 0; i < N; i++) begin
      logic [19:0] addr;
      addr = 20'hFFFFE + 20'(i);
      if (addr != 20'd1)
        im_mem[addr] = (i == 0) ? 24'h4080C0 : (i == 1) ? 24'h123456 : (24'h0F0000 | 24'(i));
      img[i] = im_mem[addr];
    end
    frame_base = 20'hFFFFE;
    run_frame(100, -1);
    total++;
    if (timed_out) begin bad++; $display("FAIL wrap_timeout: frame_done missing, got none want pulse"); end
    total++;
    if (rx_data.size() != N) begin bad++; $display("FAIL wrap_count: got %0d want %0d", rx_data.size(), N); end
    for (int i = 0; i < N && i < rx_data.size(); i++) begin
      total++;
      if ({rx_data[i], rx_sof[i], rx_eol[i]} !== {exp_px(img[i]), i == 0, (i % H) == H - 1}) begin
        bad++;
        $display("FAIL wrap_px%0d: got %h/%b/%b want %h/%b/%b", i, rx_data[i], rx_sof[i], rx_eol[i],
                 exp_px(img[i]), i == 0, (i % H) == H - 1);
      end
    end
    if (rx_data.size() > 0) begin
      total++;
`ifdef GRAY_OUT_EN
      if (rx_data[0] !== 24'h808080) begin bad++; $display("FAIL gray_px0: got %h want 808080", rx_data[0]); end
`else
      if (rx_data[0] !== 24'h4080C0) begin bad++; $display("FAIL rgb_px0: got %h want 4080c0", rx_data[0]); end
`endif
    end
  endtask

  task automatic test_start_ignored();
    load_linear();
    run_frame(100, 8);
    total++;
    if (timed_out) begin bad++; $display("FAIL restart_timeout: frame_done missing, got none want pulse"); end
    total++;
    if (rx_data.size() != N) begin bad++; $display("FAIL restart_count: got %0d want %0d", rx_data.size(), N); end
    for (int i = 0; i < N && i < rx_data.size(); i++) begin
      total++;
      if ({rx_data[i], rx_sof[i], rx_eol[i]} !== {exp_px(img[i]), i == 0, (i % H) == H - 1}) begin
        bad++;
        $display("FAIL restart_px%0d: got %h/%b/%b want %h/%b/%b", i, rx_data[i], rx_sof[i], rx_eol[i],
                 exp_px(img[i]), i == 0, (i % H) == H - 1);
      end
    end
    repeat (4) @(posedge clk);
    #1;
    total++;
    if ({busy, px_valid} !== 2'b00) begin bad++; $display("FAIL restart_no_second_frame: got busy=%b valid=%b want 0 0", busy, px_valid); end
  endtask

  task automatic test_reset_mid_frame();
    load_linear();
    start    = 1'b1;
    px_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #3;
    total++;
    if ({busy, px_valid} !== 2'b11) begin bad++; $display("FAIL pre_reset_active: got busy=%b valid=%b want 1 1", busy, px_valid); end
    reset = 1'b0;
    #1;
    total++;
    if ({IM_A, IM_WEN, px_valid, px_data, px_sof, px_eol, busy, frame_done} !==
        {20'h0, 1'b1, 1'b0, 24'h0, 4'h0}) begin
      bad++;
      $display("FAIL async_reset: got IM_A=%h WEN=%b v=%b d=%h sof=%b eol=%b busy=%b fd=%b, want IM_A=0 WEN=1 rest 0",
               IM_A, IM_WEN, px_valid, px_data, px_sof, px_eol, busy, frame_done);
    end
    px_ready = 1'b0;
    @(posedge clk); #3;
    reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL post_reset_idle: got busy=%b want 0", busy); end
    run_frame(100, -1);
    total++;
    if (timed_out) begin bad++; $display("FAIL post_reset_timeout: frame_done missing, got none want pulse"); end
    total++;
    if (first_valid != 5) begin bad++; $display("FAIL post_reset_latency: got %0d want 5", first_valid); end
    total++;
    if (rx_data.size() != N) begin bad++; $display("FAIL post_reset_count: got %0d want %0d", rx_data.size(), N); end
    for (int i = 0; i < N && i < rx_data.size(); i++) begin
      total++;
      if ({rx_data[i], rx_sof[i], rx_eol[i]} !== {exp_px(img[i]), i == 0, (i % H) == H - 1}) begin
        bad++;
        $display("FAIL post_reset_px%0d: got %h/%b/%b want %h/%b/%b", i, rx_data[i], rx_sof[i], rx_eol[i],
                 exp_px(img[i]), i == 0, (i % H) == H - 1);
      end
    end
  endtask

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    px_ready   = 1'b0;
    frame_base = '0;
    test_reset();
    test_full_rate();
    test_backpressure();
    test_addr_wrap();
    test_start_ignored();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
